// File: rtl/regbank_wr_arb_if.sv
// Request/grant bundle between write requesters and the register-bank write arbiter.
// The requester side drives req/addr/data; the arbiter drives the grant and the bank write port.
interface regbank_wr_arb_if #(
    parameter int W = 8,
    parameter int N = 4,
    parameter int A = 2
);
    localparam int DEPTH = 2 ** A;

    logic [N-1:0]     req;
    logic [N*A-1:0]   addr;
    logic [N*W-1:0]   data;
    logic [N-1:0]     gnt;
    logic [DEPTH-1:0] reg_enb;
    logic [W-1:0]     reg_d;
    logic             busy;

    modport master (
        output req, addr, data,
        input  gnt, reg_enb, reg_d, busy
    );

    modport slave (
        input  req, addr, data,
        output gnt, reg_enb, reg_d, busy
    );
endinterface

// File: rtl/regbank_wr_arb.sv
// Round-robin write arbiter: grants one requester per cycle and drives the shared
// d bus plus a one-hot load enable into a bank of 2**A registers.
module regbank_wr_arb #(
    parameter int W = 8,
    parameter int N = 4,
    parameter int A = 2
) (
    input  logic            clk,
    input  logic            rst,
    regbank_wr_arb_if.slave bus
);
    localparam int DEPTH = 2 ** A;
    localparam int PW    = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]     gnt_q,     gnt_d;
    logic [DEPTH-1:0] reg_enb_q, reg_enb_d;
    logic [W-1:0]     reg_d_q,   reg_d_d;
    logic             busy_q,    busy_d;
    logic [PW-1:0]    prio_q,    prio_d;

    logic [N-1:0]     elig;
    logic             win_vld;
    logic [PW-1:0]    win_idx;
    logic [A-1:0]     win_addr;
    logic [W-1:0]     win_data;

    function automatic int rot(input int p, input int k);
        int s;
        s = p + k;
        return (s >= N) ? s - N : s;
    endfunction

    // Current grantee is masked so a lone requester gets every other cycle.
    assign elig = bus.req & ~gnt_q;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_vld && elig[rot(int'(prio_q), k)]) begin
                win_vld = 1'b1;
                win_idx = PW'(rot(int'(prio_q), k));
            end
        end
    end

    assign win_addr = bus.addr[int'(win_idx)*A +: A];
    assign win_data = bus.data[int'(win_idx)*W +: W];

    always_comb begin
        gnt_d     = '0;
        reg_enb_d = '0;
        reg_d_d   = reg_d_q;
        busy_d    = 1'b0;
        prio_d    = prio_q;
        if (win_vld) begin
            gnt_d     = N'(1) << win_idx;
            reg_enb_d = DEPTH'(1) << win_addr;
            reg_d_d   = win_data;
            busy_d    = 1'b1;
            prio_d    = (int'(win_idx) == N - 1) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= '0;
            reg_enb_q <= '0;
            reg_d_q   <= '0;
            busy_q    <= 1'b0;
            prio_q    <= '0;
        end else begin
            gnt_q     <= gnt_d;
            reg_enb_q <= reg_enb_d;
            reg_d_q   <= reg_d_d;
            busy_q    <= busy_d;
            prio_q    <= prio_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.reg_enb = reg_enb_q;
    assign bus.reg_d   = reg_d_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_regbank_wr_arb.sv
// Directed and randomized checks of the round-robin register-bank write arbiter,
// with a small arbitration model and register-bank model for the random phase.
module tb_regbank_wr_arb;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int A     = 2;
    localparam int DEPTH = 2 ** A;
    localparam int NRAND = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regbank_wr_arb_if #(.W(W), .N(N), .A(A)) bif ();

    regbank_wr_arb #(.W(W), .N(N), .A(A)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0] r_req;
    logic [A-1:0] r_addr [N];
    logic [W-1:0] r_data [N];

    logic [W-1:0] dut_bank [DEPTH];
    logic [W-1:0] m_bank   [DEPTH];

    // Stand-in for the register_m bank, loaded from the arbiter's outputs.
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) dut_bank[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (bif.reg_enb[k]) dut_bank[k] <= bif.reg_d;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        bif.req = r_req;
        for (int i = 0; i < N; i++) begin
            bif.addr[i*A +: A] = r_addr[i];
            bif.data[i*W +: W] = r_data[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        r_req = '0;
        for (int i = 0; i < N; i++) begin
            r_addr[i] = '0;
            r_data[i] = '0;
        end
        drive();
    endtask

    task automatic set_req(input int i, input logic [A-1:0] a, input logic [W-1:0] d);
        r_req[i]  = 1'b1;
        r_addr[i] = a;
        r_data[i] = d;
        drive();
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [N-1:0] g, input logic [DEPTH-1:0] e,
                           input logic [W-1:0] d, input logic b);
        chk({tag, ".gnt"},     32'(bif.gnt),     32'(g));
        chk({tag, ".reg_enb"}, 32'(bif.reg_enb), 32'(e));
        chk({tag, ".reg_d"},   32'(bif.reg_d),   32'(d));
        chk({tag, ".busy"},    32'(bif.busy),    32'(b));
    endtask

    logic [N-1:0]     m_gnt;
    int               m_prio;
    logic [W-1:0]     m_regd;
    int               age [N];

    initial begin
        clear_reqs();
        rst = 1'b1;
        step();
        step();
        chk_out("reset", 4'b0000, 4'b0000, 8'h00, 1'b0);
        rst = 1'b0;

        // single request, no competition
        set_req(0, 2'd2, 8'hA5);
        step();
        chk_out("single", 4'b0001, 4'b0100, 8'hA5, 1'b1);
        r_req = '0;
        drive();
        step();
        chk_out("single_idle", 4'b0000, 4'b0000, 8'hA5, 1'b0);

        // all four requesting: strict rotation 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, A'(i), W'(8'h10 + i));
        for (int c = 0; c < 8; c++) begin
            step();
            chk_out($sformatf("rr%0d", c), 4'b0001 << (c % 4), 4'b0001 << (c % 4),
                    W'(8'h10 + (c % 4)), 1'b1);
        end

        // lone requester held high: granted every other cycle
        do_reset();
        set_req(0, 2'd3, 8'h5A);
        for (int c = 0; c < 6; c++) begin
            step();
            if (c % 2 == 0) chk_out($sformatf("solo%0d", c), 4'b0001, 4'b1000, 8'h5A, 1'b1);
            else            chk_out($sformatf("solo%0d", c), 4'b0000, 4'b0000, 8'h5A, 1'b0);
        end

        // two requesters on the same address are serialized, later one wins
        do_reset();
        set_req(1, 2'd1, 8'h11);
        set_req(3, 2'd1, 8'h33);
        step();
        chk_out("coll1", 4'b0010, 4'b0010, 8'h11, 1'b1);
        r_req[1] = 1'b0;
        drive();
        step();
        chk_out("coll2", 4'b1000, 4'b0010, 8'h33, 1'b1);
        clear_reqs();
        step();
        chk("coll_bank1", 32'(dut_bank[1]), 32'h33);

        // reset in the middle of a busy stream
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, A'(i), W'(8'h10 + i));
        step();
        step();
        chk_out("pre_rst", 4'b0010, 4'b0010, 8'h11, 1'b1);
        rst = 1'b1;
        step();
        chk_out("mid_rst", 4'b0000, 4'b0000, 8'h00, 1'b0);
        rst = 1'b0;
        step();
        chk_out("post_rst", 4'b0001, 4'b0001, 8'h10, 1'b1);

        // randomized traffic against a reference model
        do_reset();
        m_gnt  = '0;
        m_prio = 0;
        m_regd = '0;
        for (int k = 0; k < DEPTH; k++) m_bank[k] = '0;
        for (int i = 0; i < N; i++) age[i] = 0;
        for (int c = 0; c < NRAND; c++) begin
            logic [N-1:0]     elig;
            logic [N-1:0]     e_gnt;
            logic [DEPTH-1:0] e_enb;
            logic             found;
            int               win;
            int               j;

            elig  = r_req & ~m_gnt;
            found = 1'b0;
            win   = 0;
            for (int off = 0; off < N; off++) begin
                j = (m_prio + off) % N;
                if (!found && elig[j]) begin
                    found = 1'b1;
                    win   = j;
                end
            end
            e_gnt = '0;
            e_enb = '0;
            if (found) begin
                e_gnt[win]         = 1'b1;
                e_enb[r_addr[win]] = 1'b1;
                m_regd             = r_data[win];
                m_bank[r_addr[win]] = r_data[win];
                m_prio             = (win + 1) % N;
            end
            m_gnt = e_gnt;

            step();
            chk_out("rand", e_gnt, e_enb, m_regd, found);
            chk("rand.onehot", 32'($countones(bif.gnt) <= 1 &&
                                   $countones(bif.reg_enb) == $countones(bif.gnt)), 32'd1);

            for (int i = 0; i < N; i++) begin
                if (r_req[i]) age[i]++;
                if (e_gnt[i]) begin
                    chk($sformatf("rand.fair%0d", i), 32'(age[i] <= 2*N-1), 32'd1);
                    age[i] = 0;
                    if ($urandom_range(0, 1) == 1) begin
                        r_addr[i] = A'($urandom_range(0, DEPTH-1));
                        r_data[i] = W'($urandom_range(0, 255));
                    end else begin
                        r_req[i] = 1'b0;
                    end
                end else if (r_req[i]) begin
                    if (age[i] > 2*N-1)
                        chk($sformatf("rand.starve%0d", i), 32'(age[i]), 32'(2*N-1));
                end else begin
                    r_addr[i] = A'($urandom_range(0, DEPTH-1));
                    r_data[i] = W'($urandom_range(0, 255));
                    if ($urandom_range(0, 2) != 0) begin
                        r_req[i] = 1'b1;
                        age[i]   = 0;
                    end
                end
            end
            drive();
        end
        clear_reqs();
        step();
        step();
        for (int k = 0; k < DEPTH; k++)
            chk($sformatf("bank%0d", k), 32'(dut_bank[k]), 32'(m_bank[k]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
